// File: rtl/mult_seq_unit_if.sv
// Request/response bundle between the execute latch and mult_seq_unit.
// Signals: start, operand_a/b, ins_input in; busy, result_valid, result, overflow, ins_output out.
interface mult_seq_unit_if;
   logic        start;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] ins_input;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;
   logic        overflow;
   logic [31:0] ins_output;

   modport master (
      output start, operand_a, operand_b, ins_input,
      input  busy, result_valid, result, overflow, ins_output
   );

   modport slave (
      input  start, operand_a, operand_b, ins_input,
      output busy, result_valid, result, overflow, ins_output
   );
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative 32x32 signed radix-2 shift-add multiplier (IDLE/RUN/DONE).
// Ports: clock, reset (sync, active-high), bus (mult_seq_unit_if.slave).
// Optional MULT_EARLY_EXIT_EN: finish as soon as the multiplier empties.
module mult_seq_unit (
   input  logic             clock,
   input  logic             reset,
   mult_seq_unit_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [63:0] r_mcand;
   logic [31:0] r_mplier;
   logic [63:0] r_acc;
   logic [5:0]  r_cnt;
   logic        r_sign;
   logic [31:0] r_ins;
   logic [31:0] r_result;
   logic        r_ovf;
   logic [31:0] r_ins_out;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [63:0] w_acc_sum;
   logic [31:0] w_mplier_sh;
   logic [63:0] w_prod;
   logic        w_last;
   logic        w_accept;

   // 0x80000000 negates to itself, which is its correct unsigned magnitude
   assign w_a_mag = bus.operand_a[31] ? (~bus.operand_a + 32'd1)
                                      : bus.operand_a;
   assign w_b_mag = bus.operand_b[31] ? (~bus.operand_b + 32'd1)
                                      : bus.operand_b;

   assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
   assign w_mplier_sh = {1'b0, r_mplier[31:1]};
   assign w_prod      = r_sign ? (~w_acc_sum + 64'd1) : w_acc_sum;

`ifdef MULT_EARLY_EXIT_EN
   assign w_last = (r_cnt == 6'd31) || (w_mplier_sh == 32'd0);
`else
   assign w_last = (r_cnt == 6'd31);
`endif

   assign w_accept = (r_state != S_RUN) && bus.start;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE,
         S_DONE: w_state_nxt = bus.start ? S_RUN : S_IDLE;
         S_RUN:  if (w_last) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_ins     <= '0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_ins_out <= '0;
      end else if (w_accept) begin
         r_mcand  <= {32'd0, w_a_mag};
         r_mplier <= w_b_mag;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sign   <= bus.operand_a[31] ^ bus.operand_b[31];
         r_ins    <= bus.ins_input;
      end else if (r_state == S_RUN) begin
         r_acc    <= w_acc_sum;
         r_mcand  <= {r_mcand[62:0], 1'b0};
         r_mplier <= w_mplier_sh;
         r_cnt    <= r_cnt + 6'd1;
         // final iteration's sum feeds the signed result directly
         if (w_last) begin
            r_result  <= w_prod[31:0];
            r_ovf     <= (w_prod[63:32] != {32{w_prod[31]}});
            r_ins_out <= r_ins;
         end
      end
   end

   assign bus.busy         = (r_state == S_RUN);
   assign bus.result_valid = (r_state == S_DONE);
   assign bus.result       = r_result;
   assign bus.overflow     = r_ovf;
   assign bus.ins_output   = r_ins_out;
endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed self-checking bench for mult_seq_unit.
// Drives on the falling edge, samples on the falling edge.
module tb_mult_seq_unit;
   logic clock = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   bit   quiet;

`ifdef MULT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   mult_seq_unit_if bus ();

   mult_seq_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // edges from start sample to DONE entry
   function automatic int exp_lat(input logic [31:0] b);
      logic [31:0] m;
      int hi;
      m  = b[31] ? (~b + 32'd1) : b;
      hi = 0;
      for (int i = 0; i < 32; i++)
         if (m[i]) hi = i;
      return EARLY ? hi + 1 : 32;
   endfunction

   // caller has raised start at a falling edge; returns at the
   // falling edge where result_valid is seen (or after timeout)
   task automatic wait_done(input string tag,
                            input int lat,
                            input bit poke);
      int n;
      bit busy_ok;
      @(negedge clock);
      bus.start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      chk({tag, "_v0"}, {31'd0, bus.result_valid}, 32'd0);
      while (!bus.result_valid && n < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (poke && n == 10) begin
            bus.start     = 1'b1;
            bus.operand_a = 32'd1;
            bus.operand_b = 32'd1;
            bus.ins_input = 32'hDEAD_BEEF;
         end
         @(negedge clock);
         bus.start = 1'b0;
         n++;
      end
      chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic req(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] ins);
      bus.operand_a = a;
      bus.operand_b = b;
      bus.ins_input = ins;
      bus.start     = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      bus.start     = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.ins_input = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("rst_ins", bus.ins_output, 32'd0);

      // 7*6 with a stray start mid-run that must be ignored
      req(32'd7, 32'd6, 32'h00A1_B2C3);
      wait_done("m7x6", exp_lat(32'd6), 1'b1);
      chk("m7x6_res", bus.result, 32'd42);
      chk("m7x6_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("m7x6_ins", bus.ins_output, 32'h00A1_B2C3);

      // back-to-back chain, each start raised during DONE
      req(32'hFFFF_FFFD, 32'd5, 32'h0000_0011);
      wait_done("mn3x5", exp_lat(32'd5), 1'b0);
      chk("mn3x5_res", bus.result, 32'hFFFF_FFF1);
      chk("mn3x5_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("mn3x5_ins", bus.ins_output, 32'h0000_0011);

      req(32'h0001_0000, 32'h0001_0000, 32'h0000_0022);
      wait_done("m2p32", exp_lat(32'h0001_0000), 1'b0);
      chk("m2p32_res", bus.result, 32'd0);
      chk("m2p32_ovf", {31'd0, bus.overflow}, 32'd1);
      chk("m2p32_ins", bus.ins_output, 32'h0000_0022);

      req(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0033);
      wait_done("mmin", exp_lat(32'hFFFF_FFFF), 1'b0);
      chk("mmin_res", bus.result, 32'h8000_0000);
      chk("mmin_ovf", {31'd0, bus.overflow}, 32'd1);
      chk("mmin_ins", bus.ins_output, 32'h0000_0033);

      @(negedge clock);
      chk("idle_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("hold_res", bus.result, 32'h8000_0000);
      chk("hold_ins", bus.ins_output, 32'h0000_0033);

      // negative times negative
      req(32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'h0000_0044);
      wait_done("mneg", exp_lat(32'hFFFF_FFF7), 1'b0);
      chk("mneg_res", bus.result, 32'd63);
      chk("mneg_ovf", {31'd0, bus.overflow}, 32'd0);

      // reset partway through RUN
      @(negedge clock);
      req(32'd2, 32'h7FFF_FFFF, 32'h0000_0055);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (9) @(negedge clock);
      chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("mid_result", bus.result, 32'd0);
      chk("mid_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("mid_ins", bus.ins_output, 32'd0);
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clock);
         if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0)
            quiet = 1'b0;
      end
      chk("mid_quiet", {31'd0, quiet}, 32'd1);

      // reset and start together: reset wins
      req(32'd9, 32'd9, 32'h0000_0066);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.start = 1'b0;
      chk("rs_busy", {31'd0, bus.busy}, 32'd0);
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clock);
         if (bus.result_valid !== 1'b0) quiet = 1'b0;
      end
      chk("rs_quiet", {31'd0, quiet}, 32'd1);

      // short multipliers (early exit when enabled)
      req(32'd7, 32'd1, 32'h0000_0077);
      wait_done("m7x1", exp_lat(32'd1), 1'b0);
      chk("m7x1_res", bus.result, 32'd7);
      chk("m7x1_ins", bus.ins_output, 32'h0000_0077);
      @(negedge clock);
      req(32'd3, 32'd0, 32'h0000_0088);
      wait_done("m3x0", exp_lat(32'd0), 1'b0);
      chk("m3x0_res", bus.result, 32'd0);
      chk("m3x0_ovf", {31'd0, bus.overflow}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
